// File: rtl/mmc1_pkg.sv
// Shared types and constants for the MMC1 serial-load controller and its bank mapper.
package mmc1_pkg;

    typedef enum logic [1:0] {
        SEL_CTRL = 2'b00,
        SEL_CHR0 = 2'b01,
        SEL_CHR1 = 2'b10,
        SEL_PRG  = 2'b11
    } reg_sel_e;

    // ctrl[3:2]: both 0x codes select 32 KiB switching
    localparam logic [1:0] PRG_MODE_32K_A     = 2'b00;
    localparam logic [1:0] PRG_MODE_32K_B     = 2'b01;
    localparam logic [1:0] PRG_MODE_FIX_FIRST = 2'b10;
    localparam logic [1:0] PRG_MODE_FIX_LAST  = 2'b11;

    localparam logic [1:0] MIR_ONE_LO = 2'b00;
    localparam logic [1:0] MIR_ONE_HI = 2'b01;
    localparam logic [1:0] MIR_VERT   = 2'b10;
    localparam logic [1:0] MIR_HORZ   = 2'b11;

    localparam logic [4:0] CTRL_RST_DEFAULT = 5'h0C;
    localparam logic [2:0] SHIFT_LAST       = 3'd4;

endpackage

// File: rtl/mmc1_bank_mux.sv
// Combinational PRG/CHR bank, mirroring and PRG-RAM enable decode from the MMC1 registers.
module mmc1_bank_mux
    import mmc1_pkg::*;
(
    input  logic [4:0] ctrl_i,
    input  logic [4:0] chr0_i,
    input  logic [4:0] chr1_i,
    input  logic [4:0] prg_i,
    input  logic       cpu_a14_i,
    input  logic       ppu_a12_i,
    input  logic       ppu_a11_i,
    input  logic       ppu_a10_i,
    output logic [3:0] prg_a_o,
    output logic [4:0] chr_a_o,
    output logic       ciram_a10_o,
    output logic       wram_ce_n_o
);

    // PRG bank select by mode
    always_comb begin
        prg_a_o = {prg_i[3:1], cpu_a14_i};
        case (ctrl_i[3:2])
            PRG_MODE_FIX_FIRST: prg_a_o = cpu_a14_i ? prg_i[3:0] : 4'h0;
            PRG_MODE_FIX_LAST:  prg_a_o = cpu_a14_i ? 4'hF : prg_i[3:0];
            default:            prg_a_o = {prg_i[3:1], cpu_a14_i};
        endcase
    end

    // CHR bank select: 8 KiB or two independent 4 KiB banks
    always_comb begin
        chr_a_o = {chr0_i[4:1], ppu_a12_i};
        if (ctrl_i[4]) begin
            chr_a_o = ppu_a12_i ? chr1_i : chr0_i;
        end else begin
            chr_a_o = {chr0_i[4:1], ppu_a12_i};
        end
    end

    // Nametable mirroring
    always_comb begin
        ciram_a10_o = 1'b0;
        case (ctrl_i[1:0])
            MIR_ONE_LO: ciram_a10_o = 1'b0;
            MIR_ONE_HI: ciram_a10_o = 1'b1;
            MIR_VERT:   ciram_a10_o = ppu_a10_i;
            MIR_HORZ:   ciram_a10_o = ppu_a11_i;
            default:    ciram_a10_o = 1'b0;
        endcase
    end

    assign wram_ce_n_o = prg_i[4];

endmodule

// File: rtl/mmc1_load_ctrl.sv
// MMC1 serial register loader: 5-bit shift-in over consecutive CPU writes, plus bank mapping.
module mmc1_load_ctrl
    import mmc1_pkg::*;
#(
    parameter logic [4:0] CTRL_RST = CTRL_RST_DEFAULT
) (
    input  logic       ck,
    input  logic       nres,
    input  logic       cpu_we,
    input  logic       cpu_a14,
    input  logic       cpu_a13,
    input  logic       cpu_d0,
    input  logic       cpu_d7,
    input  logic       ppu_a12,
    input  logic       ppu_a11,
    input  logic       ppu_a10,
    output logic [4:0] ctrl,
    output logic [4:0] chr0,
    output logic [4:0] chr1,
    output logic [4:0] prg,
    output logic       load_stb,
    output logic [3:0] prg_a,
    output logic [4:0] chr_a,
    output logic       ciram_a10,
    output logic       wram_ce_n
);

    logic       we_d_q;
    logic [3:0] sr_q, sr_d;
    logic [2:0] cnt_q, cnt_d;
    logic [4:0] ctrl_q, ctrl_d;
    logic [4:0] chr0_q, chr0_d;
    logic [4:0] chr1_q, chr1_d;
    logic [4:0] prg_q, prg_d;
    logic       load_stb_q, load_stb_d;
    logic       acc_s;
    logic [2:0] cnt_eff_s;
    logic [4:0] commit_s;

    // Write acceptance, serial shift and register commit
    always_comb begin
        // Writes on consecutive cycles are a single CPU access; only the first counts
        acc_s      = cpu_we & ~we_d_q;
        cnt_eff_s  = (cnt_q > SHIFT_LAST) ? 3'd0 : cnt_q;
        commit_s   = {cpu_d0, sr_q};
        sr_d       = sr_q;
        cnt_d      = cnt_eff_s;
        ctrl_d     = ctrl_q;
        chr0_d     = chr0_q;
        chr1_d     = chr1_q;
        prg_d      = prg_q;
        load_stb_d = 1'b0;
        if (acc_s) begin
            if (cpu_d7) begin
                sr_d   = 4'h0;
                cnt_d  = 3'd0;
                ctrl_d = ctrl_q | CTRL_RST;
            end else if (cnt_eff_s == SHIFT_LAST) begin
                sr_d       = 4'h0;
                cnt_d      = 3'd0;
                load_stb_d = 1'b1;
                case (reg_sel_e'({cpu_a14, cpu_a13}))
                    SEL_CTRL: ctrl_d = commit_s;
                    SEL_CHR0: chr0_d = commit_s;
                    SEL_CHR1: chr1_d = commit_s;
                    SEL_PRG:  prg_d  = commit_s;
                    default:  ctrl_d = ctrl_q;
                endcase
            end else begin
                sr_d  = {cpu_d0, sr_q[3:1]};
                cnt_d = cnt_eff_s + 3'd1;
            end
        end else begin
            sr_d = sr_q;
        end
    end

    // State registers
    always_ff @(posedge ck or negedge nres) begin
        if (!nres) begin
            we_d_q     <= 1'b0;
            sr_q       <= 4'h0;
            cnt_q      <= 3'd0;
            ctrl_q     <= CTRL_RST;
            chr0_q     <= 5'h00;
            chr1_q     <= 5'h00;
            prg_q      <= 5'h00;
            load_stb_q <= 1'b0;
        end else begin
            we_d_q     <= cpu_we;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            ctrl_q     <= ctrl_d;
            chr0_q     <= chr0_d;
            chr1_q     <= chr1_d;
            prg_q      <= prg_d;
            load_stb_q <= load_stb_d;
        end
    end

    assign ctrl     = ctrl_q;
    assign chr0     = chr0_q;
    assign chr1     = chr1_q;
    assign prg      = prg_q;
    assign load_stb = load_stb_q;

    mmc1_bank_mux u_bank_mux (
        .ctrl_i      (ctrl_q),
        .chr0_i      (chr0_q),
        .chr1_i      (chr1_q),
        .prg_i       (prg_q),
        .cpu_a14_i   (cpu_a14),
        .ppu_a12_i   (ppu_a12),
        .ppu_a11_i   (ppu_a11),
        .ppu_a10_i   (ppu_a10),
        .prg_a_o     (prg_a),
        .chr_a_o     (chr_a),
        .ciram_a10_o (ciram_a10),
        .wram_ce_n_o (wram_ce_n)
    );

endmodule

// File: tb/tb_mmc1_load_ctrl.sv
// Directed bench for mmc1_load_ctrl: serial load sequences and a table of mapping vectors.
module tb_mmc1_load_ctrl;

    logic       ck = 1'b0;
    logic       nres = 1'b1;
    logic       cpu_we = 1'b0, cpu_a14 = 1'b0, cpu_a13 = 1'b0, cpu_d0 = 1'b0, cpu_d7 = 1'b0;
    logic       ppu_a12 = 1'b0, ppu_a11 = 1'b0, ppu_a10 = 1'b0;
    logic [4:0] ctrl, chr0, chr1, prg, chr_a;
    logic       load_stb, ciram_a10, wram_ce_n;
    logic [3:0] prg_a;

    int n_chk = 0;
    int n_fail = 0;
    logic [4:0] cur_ctrl, cur_chr0, cur_chr1, cur_prg;

    mmc1_load_ctrl dut (
        .ck(ck), .nres(nres), .cpu_we(cpu_we), .cpu_a14(cpu_a14), .cpu_a13(cpu_a13),
        .cpu_d0(cpu_d0), .cpu_d7(cpu_d7), .ppu_a12(ppu_a12), .ppu_a11(ppu_a11),
        .ppu_a10(ppu_a10), .ctrl(ctrl), .chr0(chr0), .chr1(chr1), .prg(prg),
        .load_stb(load_stb), .prg_a(prg_a), .chr_a(chr_a), .ciram_a10(ciram_a10),
        .wram_ce_n(wram_ce_n)
    );

    always #5 ck = ~ck;

    typedef struct {
        logic [4:0] ctrl, chr0, chr1, prg;
        logic       a14, p12, p11, p10;
        logic [3:0] e_prg_a;
        logic [4:0] e_chr_a;
        logic       e_ciram, e_wram;
    } map_vec_t;

    map_vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] reg_of(input logic [1:0] sel);
        case (sel)
            2'b00:   return ctrl;
            2'b01:   return chr0;
            2'b10:   return chr1;
            default: return prg;
        endcase
    endfunction

    // One spaced write; stb1 = load_stb the cycle after, stb2 = one cycle later
    task automatic wr(input logic a14, input logic a13, input logic d0, input logic d7,
                      output logic stb1, output logic stb2);
        @(negedge ck);
        cpu_we = 1'b1; cpu_a14 = a14; cpu_a13 = a13; cpu_d0 = d0; cpu_d7 = d7;
        @(negedge ck);
        cpu_we = 1'b0; cpu_d7 = 1'b0;
        stb1 = load_stb;
        @(negedge ck);
        stb2 = load_stb;
    endtask

    // Five serial writes; scramble puts the wrong address on writes 1-4
    task automatic ld(input logic [1:0] sel, input logic [4:0] val, input bit scramble);
        logic s1, s2;
        logic [1:0] a;
        for (int i = 0; i < 5; i++) begin
            a = (scramble && i < 4) ? ~sel : sel;
            wr(a[1], a[0], val[i], 1'b0, s1, s2);
            chk("ld_stb", {31'd0, s1}, {31'd0, (i == 4)});
            chk("ld_stb_clr", {31'd0, s2}, 32'd0);
        end
        chk("ld_val", {27'd0, reg_of(sel)}, {27'd0, val});
    endtask

    initial begin
        logic s1, s2;

        tbl[0]  = '{5'h10, 5'h03, 5'h07, 5'h0D, 1'b0, 1'b0, 1'b0, 1'b0, 4'hC, 5'h03, 1'b0, 1'b0};
        tbl[1]  = '{5'h10, 5'h03, 5'h07, 5'h0D, 1'b1, 1'b1, 1'b0, 1'b0, 4'hD, 5'h07, 1'b0, 1'b0};
        tbl[2]  = '{5'h00, 5'h03, 5'h07, 5'h0D, 1'b0, 1'b1, 1'b0, 1'b0, 4'hC, 5'h03, 1'b0, 1'b0};
        tbl[3]  = '{5'h00, 5'h03, 5'h07, 5'h0D, 1'b1, 1'b0, 1'b1, 1'b1, 4'hD, 5'h02, 1'b0, 1'b0};
        tbl[4]  = '{5'h0E, 5'h03, 5'h07, 5'h12, 1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 5'h02, 1'b1, 1'b1};
        tbl[5]  = '{5'h0E, 5'h03, 5'h07, 5'h12, 1'b0, 1'b1, 1'b1, 1'b0, 4'h2, 5'h03, 1'b0, 1'b1};
        tbl[6]  = '{5'h0A, 5'h03, 5'h07, 5'h12, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 5'h02, 1'b1, 1'b1};
        tbl[7]  = '{5'h0A, 5'h03, 5'h07, 5'h12, 1'b1, 1'b1, 1'b1, 1'b0, 4'h2, 5'h03, 1'b0, 1'b1};
        tbl[8]  = '{5'h03, 5'h03, 5'h07, 5'h12, 1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 5'h02, 1'b1, 1'b1};
        tbl[9]  = '{5'h03, 5'h03, 5'h07, 5'h12, 1'b0, 1'b1, 1'b0, 1'b1, 4'h2, 5'h03, 1'b0, 1'b1};
        tbl[10] = '{5'h1D, 5'h03, 5'h07, 5'h05, 1'b0, 1'b1, 1'b0, 1'b0, 4'h5, 5'h07, 1'b1, 1'b0};
        tbl[11] = '{5'h1D, 5'h03, 5'h07, 5'h05, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 5'h03, 1'b1, 1'b0};
        tbl[12] = '{5'h18, 5'h03, 5'h07, 5'h05, 1'b1, 1'b1, 1'b1, 1'b1, 4'h5, 5'h07, 1'b0, 1'b0};

        // Asynchronous reset, checked before any clock edge
        #1 nres = 1'b0;
        #1;
        chk("rst_ctrl", {27'd0, ctrl}, 32'h0C);
        chk("rst_chr0", {27'd0, chr0}, 32'h00);
        chk("rst_chr1", {27'd0, chr1}, 32'h00);
        chk("rst_prg", {27'd0, prg}, 32'h00);
        chk("rst_stb", {31'd0, load_stb}, 32'd0);
        repeat (2) @(negedge ck);
        nres = 1'b1;

        // Five writes at PRG select: d0 = 1,0,1,1,0
        ld(2'b11, 5'h0D, 1'b0);
        @(negedge ck);
        cpu_a14 = 1'b0;
        #1 chk("prg_a_0d", {28'd0, prg_a}, 32'hD);

        // Partial sequence discarded by a d7 write
        for (int i = 0; i < 3; i++) begin
            wr(1'b1, 1'b1, 1'b1, 1'b0, s1, s2);
            chk("partial_stb", {31'd0, s1}, 32'd0);
        end
        wr(1'b0, 1'b0, 1'b0, 1'b1, s1, s2);
        chk("d7_stb", {31'd0, s1}, 32'd0);
        ld(2'b01, 5'h1F, 1'b0);
        chk("d7_prg_kept", {27'd0, prg}, 32'h0D);
        chk("d7_ctrl", {27'd0, ctrl}, 32'h0C);

        // Back-to-back write: second cycle (even with d7) is ignored
        @(negedge ck);
        cpu_we = 1'b1; cpu_a14 = 1'b0; cpu_a13 = 1'b1; cpu_d0 = 1'b1; cpu_d7 = 1'b0;
        @(negedge ck);
        cpu_d7 = 1'b1;
        @(negedge ck);
        cpu_we = 1'b0; cpu_d7 = 1'b0;
        @(negedge ck);
        for (int i = 0; i < 4; i++) begin
            wr(1'b0, 1'b1, 1'b0, 1'b0, s1, s2);
            chk("b2b_stb", {31'd0, s1}, {31'd0, (i == 3)});
        end
        chk("b2b_chr0", {27'd0, chr0}, 32'h01);

        cur_ctrl = 5'h0C; cur_chr0 = 5'h01; cur_chr1 = 5'h00; cur_prg = 5'h0D;

        // Mapping table
        for (int k = 0; k < 13; k++) begin
            if (tbl[k].ctrl != cur_ctrl) begin ld(2'b00, tbl[k].ctrl, 1'b1); cur_ctrl = tbl[k].ctrl; end
            if (tbl[k].chr0 != cur_chr0) begin ld(2'b01, tbl[k].chr0, 1'b1); cur_chr0 = tbl[k].chr0; end
            if (tbl[k].chr1 != cur_chr1) begin ld(2'b10, tbl[k].chr1, 1'b1); cur_chr1 = tbl[k].chr1; end
            if (tbl[k].prg != cur_prg) begin ld(2'b11, tbl[k].prg, 1'b1); cur_prg = tbl[k].prg; end
            @(negedge ck);
            cpu_a14 = tbl[k].a14; ppu_a12 = tbl[k].p12; ppu_a11 = tbl[k].p11; ppu_a10 = tbl[k].p10;
            #1;
            chk($sformatf("map%0d_prg_a", k), {28'd0, prg_a}, {28'd0, tbl[k].e_prg_a});
            chk($sformatf("map%0d_chr_a", k), {27'd0, chr_a}, {27'd0, tbl[k].e_chr_a});
            chk($sformatf("map%0d_ciram", k), {31'd0, ciram_a10}, {31'd0, tbl[k].e_ciram});
            chk($sformatf("map%0d_wram", k), {31'd0, wram_ce_n}, {31'd0, tbl[k].e_wram});
        end

        // d7 ORs the reset value into ctrl (0x18 | 0x0C)
        wr(1'b0, 1'b0, 1'b0, 1'b1, s1, s2);
        chk("d7_or_ctrl", {27'd0, ctrl}, 32'h1C);

        // Reset after four shifted bits, then reload ctrl with zeros
        for (int i = 0; i < 4; i++) wr(1'b0, 1'b0, 1'b1, 1'b0, s1, s2);
        @(negedge ck);
        nres = 1'b0;
        #1;
        chk("mid_rst_ctrl", {27'd0, ctrl}, 32'h0C);
        chk("mid_rst_chr0", {27'd0, chr0}, 32'h00);
        chk("mid_rst_prg", {27'd0, prg}, 32'h00);
        repeat (2) @(negedge ck);
        nres = 1'b1;
        cpu_we = 1'b1; cpu_a14 = 1'b0; cpu_a13 = 1'b0; cpu_d0 = 1'b0; cpu_d7 = 1'b0;
        ppu_a10 = 1'b1; ppu_a11 = 1'b1;
        @(negedge ck);
        cpu_we = 1'b0;
        chk("rel_stb1", {31'd0, load_stb}, 32'd0);
        @(negedge ck);
        for (int i = 0; i < 4; i++) begin
            wr(1'b0, 1'b0, 1'b0, 1'b0, s1, s2);
            chk("rel_stb", {31'd0, s1}, {31'd0, (i == 3)});
        end
        chk("rel_ctrl", {27'd0, ctrl}, 32'h00);
        chk("rel_ciram", {31'd0, ciram_a10}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
